rs232_tx_fifo: RTL and testbench

//   Parametrised RS-232 transmitter: buffers words in a small FIFO and serialises them
//   as start + DATA_BITS (LSB first) + optional parity + STOP_BITS stop bits at a fixed

---
 rtl/rs232_pkg.sv | 36 +++
 rtl/sync_fifo.sv | 87 ++++++++
 rtl/rs232_tx_fifo.sv | 222 ++++++++++++++++++++++
 tb/tb_rs232_tx_fifo.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared definitions for the RS-232 transmit (and future receive) path.
//   - parity mode constants PAR_NONE / PAR_ODD / PAR_EVEN
//   - transmit FSM state encoding
//   - frame_bits(): total bit periods in one frame
//   - parity_bit(): parity bit for a payload word under a given parity mode
package rs232_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Number of bit periods in a frame: start + payload + optional parity + stop bits.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  // Payload is zero-extended to 9 bits by the caller; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [8:0] d, input int parity);
    logic p;
    p = ^d;
    case (parity)
      PAR_ODD:  return p ^ 1'b1;
      PAR_EVEN: return p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data.
//   Ports:
//     clk, rst            clock, synchronous active-high reset
//     i_push, i_wdata     write strobe and data; ignored while full
//     i_pop               read strobe; ignored while empty
//     o_rdata             word popped on the previous cycle (valid the cycle after pop)
//     o_full, o_empty     registered status flags
//     o_level             registered number of stored words (0..DEPTH)
//   Fullness is judged on the current contents, so a push into a full FIFO is
//   dropped even when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [LW-1:0]    r_wptr;
  logic [LW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic [WIDTH-1:0] r_rdata;
  logic             r_full;
  logic             r_empty;
  logic             w_push_ok;
  logic             w_pop_ok;
  logic [LW-1:0]    w_level_next;

  assign w_push_ok = i_push & ~r_full;
  assign w_pop_ok  = i_pop & ~r_empty;

  // Next occupancy: simultaneous accepted push and pop leaves it unchanged.
  always_comb begin
    w_level_next = r_level;
    case ({w_push_ok, w_pop_ok})
      2'b10:   w_level_next = r_level + LW'(1);
      2'b01:   w_level_next = r_level - LW'(1);
      default: w_level_next = r_level;
    endcase
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end
  end

  // Pointers, occupancy, status flags and registered read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_rdata <= '0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + LW'(1);
      end
      if (w_pop_ok) begin
        r_rptr  <= r_rptr + LW'(1);
        r_rdata <= r_mem[r_rptr[AW-1:0]];
      end
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(DEPTH));
      r_empty <= (w_level_next == '0);
    end
  end

  assign o_rdata = r_rdata;
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;

endmodule

// File: rtl/rs232_tx_fifo.sv
// rs232_tx_fifo: buffered RS-232 transmitter.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset; aborts any frame in flight
//     data        word to send, sampled when send = 1
//     send        write strobe, one word per cycle
//     ovf_clr     clears the sticky overflow flag (a same-cycle overflow wins)
//     UART_TX     serial line, idle high, driven straight from a flop
//     uart_ovf    sticky: a send was dropped because the FIFO was full
//     sending     FIFO non-empty or a frame in flight
//     fifo_level  words queued, excluding the one being transmitted
//   Frame: start(0) + DATA_BITS LSB first + optional parity + STOP_BITS stop(1),
//   each bit CLKS_PER_BIT cycles. Back-to-back frames have no idle gap.
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          data,
  input  logic                          send,
  input  logic                          ovf_clr,
  output logic                          UART_TX,
  output logic                          uart_ovf,
  output logic                          sending,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_DATA   = 4'(DATA_BITS - 1);
  localparam logic [3:0]  LAST_STOP   = 4'(STOP_BITS - 1);

  tx_state_t            r_state;
  tx_state_t            w_state_next;
  logic [15:0]          r_baud;
  logic [3:0]           r_bit;
  logic [DATA_BITS-1:0] r_sr;
  logic                 r_par;
  logic                 r_load;
  logic                 r_tx;
  logic                 r_ovf;
  logic                 r_sending;

  logic                 w_bit_end;
  logic                 w_pop;
  logic                 w_shift;
  logic                 w_tx_next;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic [LW-1:0]        w_level;
  logic [LW-1:0]        w_level_next;
  logic [DATA_BITS-1:0] w_rdata;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (send),
    .i_wdata (data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  assign w_bit_end    = (r_baud == 16'd0);
  assign w_push_ok    = send & ~w_full;
  // w_pop is only raised while the FIFO is non-empty, so this never underflows.
  assign w_level_next = w_level + LW'(w_push_ok) - LW'(w_pop);

  // Next-state logic; w_tx_next is the line level for the period being entered.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift      = 1'b0;
    w_tx_next    = r_tx;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
        end else begin
          w_tx_next = 1'b1;
        end
      end
      ST_START: begin
        // Shifting on entry to each data bit keeps the next bit in r_sr[0].
        if (w_bit_end) begin
          w_state_next = ST_DATA;
          w_shift      = 1'b1;
          w_tx_next    = r_sr[0];
        end else begin
          w_tx_next = 1'b0;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit == LAST_DATA) begin
            if (PARITY != PAR_NONE) begin
              w_state_next = ST_PARITY;
              w_tx_next    = r_par;
            end else begin
              w_state_next = ST_STOP;
              w_tx_next    = 1'b1;
            end
          end else begin
            w_shift   = 1'b1;
            w_tx_next = r_sr[0];
          end
        end else begin
          w_shift = 1'b0;
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
          w_tx_next    = 1'b1;
        end else begin
          w_tx_next = r_par;
        end
      end
      ST_STOP: begin
        // Chaining straight into the next start bit avoids an idle gap.
        if (w_bit_end && (r_bit == LAST_STOP)) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_state_next = ST_START;
            w_tx_next    = 1'b0;
          end else begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
          end
        end else begin
          w_tx_next = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
  end

  // FSM state, baud counter and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_baud  <= BAUD_RELOAD;
      r_bit   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_IDLE) || w_bit_end) begin
        r_baud <= BAUD_RELOAD;
      end else begin
        r_baud <= r_baud - 16'd1;
      end
      if (w_state_next != r_state) begin
        r_bit <= 4'd0;
      end else if (w_bit_end) begin
        r_bit <= r_bit + 4'd1;
      end else begin
        r_bit <= r_bit;
      end
    end
  end

  // Shift register and parity flop; FIFO read data arrives the cycle after the pop,
  // which is still inside the start bit since a bit lasts at least two cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_load <= 1'b0;
      r_sr   <= '0;
      r_par  <= 1'b0;
    end else begin
      r_load <= w_pop;
      if (r_load) begin
        r_sr  <= w_rdata;
        r_par <= parity_bit(9'(w_rdata), PARITY);
      end else if (w_shift) begin
        r_sr <= r_sr >> 1;
      end else begin
        r_sr <= r_sr;
      end
    end
  end

  // Registered line driver, sticky overflow (set beats clear) and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx      <= 1'b1;
      r_ovf     <= 1'b0;
      r_sending <= 1'b0;
    end else begin
      r_tx <= w_tx_next;
      if (send && w_full) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
      r_sending <= (w_state_next != ST_IDLE) || (w_level_next != '0);
    end
  end

  assign UART_TX    = r_tx;
  assign uart_ovf   = r_ovf;
  assign sending    = r_sending;
  assign fifo_level = w_level;

endmodule

// File: tb/tb_rs232_tx_fifo.sv
// tb_rs232_tx_fifo: directed bench for rs232_tx_fifo. Four instances cover
// 8N1, 8E1 and 8O2 at 4 clocks/bit, plus 5N1 at 2 clocks/bit.
module tb_rs232_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       clr_n1, clr_x;
  logic [7:0] data_n1, data_e1, data_o2;
  logic [4:0] data_b5;
  logic       send_n1, send_e1, send_o2, send_b5;
  logic       tx_n1, tx_e1, tx_o2, tx_b5;
  logic       ovf_n1, ovf_e1, ovf_o2, ovf_b5;
  logic       snd_n1, snd_e1, snd_o2, snd_b5;
  logic [2:0] lvl_n1, lvl_e1, lvl_o2, lvl_b5;
  logic [3:0] tx_v, snd_v;
  logic [7:0] words [0:5];

  int checks = 0;
  int errors = 0;

  assign tx_v  = {tx_b5, tx_o2, tx_e1, tx_n1};
  assign snd_v = {snd_b5, snd_o2, snd_e1, snd_n1};

  rs232_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_n1 (
    .clk(clk), .rst(rst), .data(data_n1), .send(send_n1), .ovf_clr(clr_n1),
    .UART_TX(tx_n1), .uart_ovf(ovf_n1), .sending(snd_n1), .fifo_level(lvl_n1));
  rs232_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_e1 (
    .clk(clk), .rst(rst), .data(data_e1), .send(send_e1), .ovf_clr(clr_x),
    .UART_TX(tx_e1), .uart_ovf(ovf_e1), .sending(snd_e1), .fifo_level(lvl_e1));
  rs232_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u_o2 (
    .clk(clk), .rst(rst), .data(data_o2), .send(send_o2), .ovf_clr(clr_x),
    .UART_TX(tx_o2), .uart_ovf(ovf_o2), .sending(snd_o2), .fifo_level(lvl_o2));
  rs232_tx_fifo #(.CLKS_PER_BIT(2), .DATA_BITS(5), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_b5 (
    .clk(clk), .rst(rst), .data(data_b5), .send(send_b5), .ovf_clr(clr_x),
    .UART_TX(tx_b5), .uart_ovf(ovf_b5), .sending(snd_b5), .fifo_level(lvl_b5));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that starts a frame; returns just after the edge that ends it.
  task automatic check_frame(input string tag, input int d, input logic [15:0] exp,
                             input int nb, input int cpb);
    logic [15:0] e;
    e = exp;
    for (int i = 0; i < nb * cpb; i++) begin
      check(tag, 16'(tx_v[d]), 16'(e[i / cpb]));
      check({tag, "_sending"}, 16'(snd_v[d]), 16'd1);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; clr_n1 = 1'b0; clr_x = 1'b0;
    send_n1 = 1'b0; send_e1 = 1'b0; send_o2 = 1'b0; send_b5 = 1'b0;
    data_n1 = 8'h00; data_e1 = 8'h00; data_o2 = 8'h00; data_b5 = 5'h00;
    words[0] = 8'h3C; words[1] = 8'h11; words[2] = 8'h22;
    words[3] = 8'h33; words[4] = 8'h44; words[5] = 8'h55;
    tick();
    tick();
    rst = 1'b0;

    // Reset state of every instance
    check("rst_tx",  16'({tx_b5, tx_o2, tx_e1, tx_n1}), 16'hF);
    check("rst_ovf", 16'({ovf_b5, ovf_o2, ovf_e1, ovf_n1}), 16'h0);
    check("rst_snd", 16'({snd_b5, snd_o2, snd_e1, snd_n1}), 16'h0);
    check("rst_lvl", 16'({lvl_b5, lvl_o2, lvl_e1, lvl_n1}), 16'h0);

    // 1: 8N1 0xA5, start bit one cycle after acceptance
    data_n1 = 8'hA5; send_n1 = 1'b1;
    tick();
    send_n1 = 1'b0;
    check("t1_lvl_k", 16'(lvl_n1), 16'd1);
    check("t1_snd_k", 16'(snd_n1), 16'd1);
    check("t1_tx_k",  16'(tx_n1), 16'd1);
    tick();
    check("t1_lvl_pop", 16'(lvl_n1), 16'd0);
    check_frame("t1_frame", 0, 16'b1101001010, 10, 4);
    check("t1_tx_end",  16'(tx_n1), 16'd1);
    check("t1_snd_end", 16'(snd_n1), 16'd0);

    // 2: 8E1 0x07 (parity 1), 8O2 0x07 (parity 0, two stop bits)
    data_e1 = 8'h07; send_e1 = 1'b1;
    tick();
    send_e1 = 1'b0;
    tick();
    check_frame("t2_8e1", 1, 16'b11000001110, 11, 4);
    check("t2_8e1_snd_end", 16'(snd_e1), 16'd0);
    data_o2 = 8'h07; send_o2 = 1'b1;
    tick();
    send_o2 = 1'b0;
    tick();
    check_frame("t2_8o2", 2, 16'b110000001110, 12, 4);
    check("t2_8o2_snd_end", 16'(snd_o2), 16'd0);

    // 6: 5N1 at 2 clocks/bit, 7-bit frame of 14 cycles
    data_b5 = 5'h1F; send_b5 = 1'b1;
    tick();
    send_b5 = 1'b0;
    tick();
    check_frame("t6_5n1", 3, 16'b1111110, 7, 2);
    check("t6_tx_end",  16'(tx_b5), 16'd1);
    check("t6_snd_end", 16'(snd_b5), 16'd0);

    // 3: six back-to-back sends: one in flight, four queued, the last dropped
    for (int i = 0; i < 6; i++) begin
      data_n1 = words[i]; send_n1 = 1'b1;
      tick();
    end
    send_n1 = 1'b0;
    check("t3_lvl_full", 16'(lvl_n1), 16'd4);
    check("t3_ovf",      16'(ovf_n1), 16'd1);
    for (int i = 0; i < 36; i++) tick();
    check("t3_lvl_chain", 16'(lvl_n1), 16'd3);
    for (int i = 1; i < 5; i++) begin
      check_frame("t3_frame", 0, 16'({1'b1, words[i], 1'b0}), 10, 4);
    end
    check("t3_tx_end",  16'(tx_n1), 16'd1);
    check("t3_snd_end", 16'(snd_n1), 16'd0);
    check("t3_lvl_end", 16'(lvl_n1), 16'd0);

    // 4: clear alone, then clear racing an overflow, then clear alone
    clr_n1 = 1'b1;
    tick();
    clr_n1 = 1'b0;
    check("t4_clr_alone", 16'(ovf_n1), 16'd0);
    for (int i = 0; i < 5; i++) begin
      data_n1 = words[i]; send_n1 = 1'b1;
      tick();
    end
    data_n1 = words[5]; send_n1 = 1'b1; clr_n1 = 1'b1;
    tick();
    send_n1 = 1'b0;
    check("t4_set_wins", 16'(ovf_n1), 16'd1);
    check("t4_lvl",      16'(lvl_n1), 16'd4);
    tick();
    clr_n1 = 1'b0;
    check("t4_clr_after", 16'(ovf_n1), 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_rst_lvl", 16'(lvl_n1), 16'd0);

    // 5: reset mid-DATA with two words queued; all-zero words would pull the line low
    for (int i = 0; i < 3; i++) begin
      data_n1 = 8'h00; send_n1 = 1'b1;
      tick();
    end
    send_n1 = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check("t5_lvl_pre", 16'(lvl_n1), 16'd2);
    check("t5_snd_pre", 16'(snd_n1), 16'd1);
    check("t5_tx_pre",  16'(tx_n1), 16'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_tx_rst",  16'(tx_n1), 16'd1);
    check("t5_lvl_rst", 16'(lvl_n1), 16'd0);
    check("t5_snd_rst", 16'(snd_n1), 16'd0);
    for (int i = 0; i < 40; i++) begin
      tick();
      check("t5_quiet", 16'(tx_n1), 16'd1);
    end
    check("t5_snd_quiet", 16'(snd_n1), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
